filtro_load: RTL and testbench
==============================

// Module: filtro_load
// PURPOSE
//   MEM-stage load unit for the MIPS datapath; the read-side counterpart of the store filter.
//   - Accepts a load request (LW/LH/LB, signed or unsigned) and issues one word-aligned read to data memory.
//   - Waits a variable number of cycles for memory-ready.
//   - Extracts the addressed byte or halfword (little-endian) and sign- or zero-extends it to NBITS.
//   - Drives o_Stall to freeze the pipeline until the result or an error is delivered.
// PARAMETERS
//   NBITS      32  data width
//   TNBITS     2   width of size code (00 LW, 01 LB, 10 LH, 11 invalid)
//   NADDR      32  byte-address width
//   MAX_ESPERA 8   max LEER cycles waiting for i_MemListo before timeout (>=1)
// PORTS
//   i_clk              in   1      clock; all state changes on its rising edge
//   i_reset            in   1      asynchronous, active-low reset
//   i_Load             in   1      load request, sampled only in IDLE
//   i_Direccion        in   NADDR  byte address of load
//   i_Tamano           in   TNBITS size code
//   i_Signo            in   1      1 = sign-extend, 0 = zero-extend (ignored for LW)
//   o_MemLeer          out  1      memory read strobe
//   o_MemDireccion     out  NADDR  word-aligned address {addr[NADDR-1:2],2'b00}
//   i_MemDato          in   NBITS  memory read data, valid when i_MemListo=1
//   i_MemListo         in   1      memory data ready
//   o_DatoLeido        out  NBITS  extended load result, held until next result/error
//   o_Valido           out  1      one-cycle pulse: o_DatoLeido updated with good data
//   o_ErrorAlineacion  out  1      one-cycle pulse: misaligned or invalid size
//   o_ErrorTimeout     out  1      one-cycle pulse: memory did not answer
//   o_Stall            out  1      pipeline stall request
// BEHAVIOUR
//   Reset (i_reset=0, async):
//   - state=IDLE; counter=0; all outputs 0, including o_DatoLeido.
//   - o_MemLeer drops immediately; an in-flight read is abandoned.
//   States:
//   - IDLE: i_Load=1 latches addr, i_Tamano, i_Signo.
//     - Aligned and valid -> LEER.
//     - Otherwise -> ERROR.
//     - i_Load=0 -> stay in IDLE.
//   - Alignment rules:
//     - LW requires addr[1:0]=00.
//     - LH requires addr[0]=0.
//     - LB is always aligned.
//     - Size 11 is always an error.
//   - LEER:
//     - o_MemLeer=1 and o_MemDireccion driven from latched addr.
//     - i_MemListo=1 at an edge: register result into o_DatoLeido, pulse o_Valido next cycle, -> IDLE.
//     - Else counter++; counter reaches MAX_ESPERA -> ERROR with timeout flag.
//   - ERROR: lasts one cycle.
//     - Pulses o_ErrorAlineacion or o_ErrorTimeout (never both).
//     - o_DatoLeido = all ones (matches store filter invalid-size value).
//     - -> IDLE.
//   Extraction:
//   - LW: o_DatoLeido = i_MemDato.
//   - LB: byte = i_MemDato[8*addr[1:0] +: 8].
//   - LH: half = i_MemDato[16*addr[1] +: 16].
//   - Upper bits = MSB replicated if i_Signo=1, else 0.
//   Timing:
//   - Zero-wait memory: i_Load at edge k; o_MemLeer high in cycle k+1; o_Valido high in cycle k+2.
//   - Each extra wait cycle adds one cycle.
//   - o_MemLeer high for exactly (wait+1) cycles; never high for an error request.
//   Stall:
//   - o_Stall = (state==LEER) | (state==IDLE & i_Load), combinational.
//   - o_Stall is low in the o_Valido cycle and in the ERROR cycle.
//   Boundaries:
//   - i_Load while in LEER or ERROR is ignored.
//   - i_Load in the same cycle as the o_Valido pulse is accepted, so back-to-back loads work.
//   - i_MemListo outside LEER is ignored.
//   - Counter clears on every LEER entry.
// TESTING
//   Signed byte load:
//     LB, addr 0x103, mem 0x80FF1234, i_Signo=1 -> o_DatoLeido 0xFFFFFF80.
//     Same with i_Signo=0 -> 0x00000080.
//     Both with o_Valido pulsed 2 cycles after i_Load.
//   Halfword loads:
//     LH, addr 0x002, mem 0xBEEF0000 -> 0xFFFFBEEF (signed), 0x0000BEEF (unsigned).
//     Addr 0x000 -> 0x00000000.
//   Word load with wait states:
//     LW, addr 0x1000, i_MemListo after 3 wait cycles -> o_MemDireccion 0x1000, o_MemLeer high 4 cycles,
//     o_Stall high throughout, o_Valido once with the word.
//   Misaligned / invalid size:
//     LH addr 0x001 -> o_ErrorAlineacion pulse, o_MemLeer never high, o_DatoLeido 0xFFFFFFFF.
//     Size 11 -> same response.
//   Timeout:
//     MAX_ESPERA=4, i_MemListo held 0 -> exactly 4 LEER cycles, then o_ErrorTimeout pulse, o_Valido stays 0.
//   Reset mid-read and back-to-back:
//     i_reset=0 mid-LEER -> o_MemLeer and o_Stall drop asynchronously; next load completes normally.
//     Two consecutive LB loads -> second accepted in first's o_Valido cycle.

Source files
------------

// File: rtl/filtro_load.sv
// rtl/filtro_load.sv - MEM-stage load unit: aligned word read, byte/halfword extract, extend, stall
module filtro_load #(
  parameter int NBITS      = 32,
  parameter int TNBITS     = 2,
  parameter int NADDR      = 32,
  parameter int MAX_ESPERA = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_Load,
  input  logic [NADDR-1:0]  i_Direccion,
  input  logic [TNBITS-1:0] i_Tamano,
  input  logic              i_Signo,
  output logic              o_MemLeer,
  output logic [NADDR-1:0]  o_MemDireccion,
  input  logic [NBITS-1:0]  i_MemDato,
  input  logic              i_MemListo,
  output logic [NBITS-1:0]  o_DatoLeido,
  output logic              o_Valido,
  output logic              o_ErrorAlineacion,
  output logic              o_ErrorTimeout,
  output logic              o_Stall
);

  // Counter must be able to hold MAX_ESPERA-1; one extra bit keeps the width >= 1.
  localparam int CW = $clog2(MAX_ESPERA + 1);

  localparam logic [TNBITS-1:0] T_LW = TNBITS'(0);
  localparam logic [TNBITS-1:0] T_LB = TNBITS'(1);
  localparam logic [TNBITS-1:0] T_LH = TNBITS'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEER  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     counter, counter_next;
  logic [NADDR-1:0]  addr_q;
  logic [TNBITS-1:0] tam_q;
  logic              signo_q;
  logic              timeout_q, timeout_next;
  logic [NBITS-1:0]  dato_q, dato_next;
  logic              valido_q, valido_next;
  logic              capture;

  // Alignment rule: LW needs addr[1:0]==0, LH needs addr[0]==0, LB always fine, other codes invalid.
  function automatic logic aligned(input logic [NADDR-1:0] a, input logic [TNBITS-1:0] t);
    logic ok;
    ok = 1'b0;
    if (t == T_LW)      ok = (a[1:0] == 2'b00);
    else if (t == T_LH) ok = (a[0] == 1'b0);
    else if (t == T_LB) ok = 1'b1;
    return ok;
  endfunction

  // Little-endian lane select from the memory word followed by sign or zero extension.
  function automatic logic [NBITS-1:0] extract(input logic [NBITS-1:0] d,
                                               input logic [NADDR-1:0] a,
                                               input logic [TNBITS-1:0] t,
                                               input logic s);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [NBITS-1:0] r;
    b = d[{a[1:0], 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    r = d;
    if (t == T_LB)      r = {{(NBITS-8){s & b[7]}}, b};
    else if (t == T_LH) r = {{(NBITS-16){s & h[15]}}, h};
    return r;
  endfunction

  // State, wait counter, result register and the one-cycle valid pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      counter   <= '0;
      timeout_q <= 1'b0;
      dato_q    <= '0;
      valido_q  <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      timeout_q <= timeout_next;
      dato_q    <= dato_next;
      valido_q  <= valido_next;
    end
  end

  // Request latch: address, size and sign mode are captured when a load is accepted in IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q  <= '0;
      tam_q   <= '0;
      signo_q <= 1'b0;
    end else if (capture) begin
      addr_q  <= i_Direccion;
      tam_q   <= i_Tamano;
      signo_q <= i_Signo;
    end
  end

  // Next-state logic: accept in IDLE, wait for memory in LEER, one-cycle ERROR report.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    timeout_next = timeout_q;
    dato_next    = dato_q;
    valido_next  = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (i_Load) begin
          capture = 1'b1;
          if (aligned(i_Direccion, i_Tamano)) begin
            state_next   = LEER;
            counter_next = '0;
          end else begin
            state_next   = ERROR;
            timeout_next = 1'b0;
            dato_next    = '1;
          end
        end
      end
      LEER: begin
        if (i_MemListo) begin
          state_next  = IDLE;
          dato_next   = extract(i_MemDato, addr_q, tam_q, signo_q);
          valido_next = 1'b1;
        end else if (counter == CW'(MAX_ESPERA - 1)) begin
          state_next   = ERROR;
          timeout_next = 1'b1;
          dato_next    = '1;
          counter_next = '0;
        end else begin
          counter_next = counter + CW'(1);
        end
      end
      ERROR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; the stall also covers the request cycle itself.
  always_comb begin
    o_MemLeer         = (state == LEER);
    o_MemDireccion    = (state == LEER) ? {addr_q[NADDR-1:2], 2'b00} : '0;
    o_DatoLeido       = dato_q;
    o_Valido          = valido_q;
    o_ErrorAlineacion = (state == ERROR) & ~timeout_q;
    o_ErrorTimeout    = (state == ERROR) & timeout_q;
    o_Stall           = (state == LEER) | ((state == IDLE) & i_Load);
  end

endmodule

// File: tb/tb_filtro_load.sv
// tb/tb_filtro_load.sv - randomized and directed checks of filtro_load against a reference model
module tb_filtro_load;

  localparam int MAXW = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_Load;
  logic [31:0] i_Direccion;
  logic [1:0]  i_Tamano;
  logic        i_Signo;
  logic        o_MemLeer;
  logic [31:0] o_MemDireccion;
  logic [31:0] i_MemDato;
  logic        i_MemListo;
  logic [31:0] o_DatoLeido;
  logic        o_Valido;
  logic        o_ErrorAlineacion;
  logic        o_ErrorTimeout;
  logic        o_Stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_dato;

  filtro_load #(.NBITS(32), .TNBITS(2), .NADDR(32), .MAX_ESPERA(MAXW)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_Load(i_Load),
    .i_Direccion(i_Direccion),
    .i_Tamano(i_Tamano),
    .i_Signo(i_Signo),
    .o_MemLeer(o_MemLeer),
    .o_MemDireccion(o_MemDireccion),
    .i_MemDato(i_MemDato),
    .i_MemListo(i_MemListo),
    .o_DatoLeido(o_DatoLeido),
    .o_Valido(o_Valido),
    .o_ErrorAlineacion(o_ErrorAlineacion),
    .o_ErrorTimeout(o_ErrorTimeout),
    .o_Stall(o_Stall)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ok(input logic [31:0] a, input logic [1:0] t);
    int unsigned ai;
    ai = a;
    if (t == 2'd0) return (ai % 4) == 0;
    if (t == 2'd2) return (ai % 2) == 0;
    if (t == 2'd1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_val(input logic [31:0] a, input logic [1:0] t,
                                             input logic s, input logic [31:0] m);
    longint v;
    longint unsigned mu;
    int unsigned ai;
    mu = m;
    ai = a;
    if (t == 2'd0) return m;
    if (t == 2'd1) begin
      v = longint'((mu / (64'd1 << (8 * (ai % 4)))) % 256);
      if (s && v >= 128) v = v - 256;
    end else begin
      v = longint'((mu / (64'd1 << (16 * ((ai / 2) % 2)))) % 65536);
      if (s && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  task automatic start_load(input logic [31:0] a, input logic [1:0] t, input logic s,
                            input logic [31:0] m);
    i_Load      = 1'b1;
    i_Direccion = a;
    i_Tamano    = t;
    i_Signo     = s;
    i_MemDato   = m;
    i_MemListo  = 1'b0;
  endtask

  // Issues one load; waits = cycles of i_MemListo low in LEER before it rises.
  task automatic run_load(input logic [31:0] a, input logic [1:0] t, input logic s,
                          input logic [31:0] m, input int waits, input bit b2b,
                          output bit good);
    logic [31:0] exp;
    int n;
    if (!b2b) begin
      @(posedge i_clk); #1;
      chk("held_result", o_DatoLeido, last_dato);
    end
    start_load(a, t, s, m);
    #1;
    chk("stall_on_request", o_Stall, 1);
    chk("no_read_in_idle", o_MemLeer, 0);
    @(posedge i_clk); #1;
    i_Load = 1'b0;
    exp = model_val(a, t, s, m);
    good = 1'b0;
    if (!model_ok(a, t)) begin
      @(negedge i_clk);
      chk("align_err_pulse", o_ErrorAlineacion, 1);
      chk("align_no_timeout", o_ErrorTimeout, 0);
      chk("align_no_read", o_MemLeer, 0);
      chk("align_no_valid", o_Valido, 0);
      chk("align_no_stall", o_Stall, 0);
      chk("align_err_data", o_DatoLeido, 32'hFFFF_FFFF);
      last_dato = 32'hFFFF_FFFF;
      i_Load = 1'($urandom % 2);
    end else begin
      n = (waits < MAXW) ? waits + 1 : MAXW;
      for (int c = 0; c < n; c++) begin
        i_MemListo = (c == waits);
        i_Load = 1'($urandom % 2);
        @(negedge i_clk);
        chk("read_strobe", o_MemLeer, 1);
        chk("read_addr", o_MemDireccion, a & 32'hFFFF_FFFC);
        chk("read_stall", o_Stall, 1);
        chk("read_no_valid", o_Valido, 0);
        @(posedge i_clk); #1;
      end
      i_Load = 1'b0;
      i_MemListo = 1'b0;
      @(negedge i_clk);
      chk("done_no_read", o_MemLeer, 0);
      chk("done_no_stall", o_Stall, 0);
      chk("done_no_align_err", o_ErrorAlineacion, 0);
      if (waits < MAXW) begin
        chk("valid_pulse", o_Valido, 1);
        chk("no_timeout", o_ErrorTimeout, 0);
        chk("load_data", o_DatoLeido, exp);
        last_dato = exp;
        good = 1'b1;
      end else begin
        chk("timeout_pulse", o_ErrorTimeout, 1);
        chk("timeout_no_valid", o_Valido, 0);
        chk("timeout_data", o_DatoLeido, 32'hFFFF_FFFF);
        last_dato = 32'hFFFF_FFFF;
        i_Load = 1'($urandom % 2);
      end
    end
  endtask

  initial begin
    bit g;
    bit prev_good;
    logic [31:0] ra, rm;
    logic [1:0]  rt;
    int rw;
    i_reset = 1'b0;
    i_Load = 1'b0;
    i_Direccion = '0;
    i_Tamano = '0;
    i_Signo = 1'b0;
    i_MemDato = '0;
    i_MemListo = 1'b0;
    last_dato = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_read", o_MemLeer, 0);
    chk("reset_addr", o_MemDireccion, 0);
    chk("reset_data", o_DatoLeido, 0);
    chk("reset_valid", o_Valido, 0);
    chk("reset_errs", {o_ErrorAlineacion, o_ErrorTimeout}, 0);
    chk("reset_stall", o_Stall, 0);
    i_reset = 1'b1;

    // Signed and unsigned byte loads, zero wait.
    run_load(32'h103, 2'd1, 1'b1, 32'h80FF_1234, 0, 1'b0, g);
    run_load(32'h103, 2'd1, 1'b0, 32'h80FF_1234, 0, 1'b0, g);
    // Halfword loads.
    run_load(32'h002, 2'd2, 1'b1, 32'hBEEF_0000, 0, 1'b0, g);
    run_load(32'h002, 2'd2, 1'b0, 32'hBEEF_0000, 0, 1'b0, g);
    run_load(32'h000, 2'd2, 1'b1, 32'hBEEF_0000, 0, 1'b0, g);
    // Word with three wait cycles.
    run_load(32'h1000, 2'd0, 1'b1, 32'hCAFE_F00D, 3, 1'b0, g);
    // Misaligned halfword and invalid size.
    run_load(32'h001, 2'd2, 1'b0, 32'h1111_2222, 0, 1'b0, g);
    run_load(32'h004, 2'd3, 1'b0, 32'h1111_2222, 0, 1'b0, g);
    // Timeout: memory never answers.
    run_load(32'h2000, 2'd0, 1'b0, 32'h5555_AAAA, 20, 1'b0, g);

    // Memory ready outside LEER must be ignored.
    @(posedge i_clk); #1;
    i_Load = 1'b0;
    i_MemListo = 1'b1;
    i_MemDato = 32'h0BAD_0BAD;
    repeat (3) begin
      @(negedge i_clk);
      chk("idle_ready_no_valid", o_Valido, 0);
      chk("idle_ready_held", o_DatoLeido, last_dato);
    end
    i_MemListo = 1'b0;

    // Reset in the middle of a read.
    @(posedge i_clk); #1;
    start_load(32'h3000, 2'd0, 1'b0, 32'h1234_5678);
    @(posedge i_clk); #1;
    i_Load = 1'b0;
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    #1;
    chk("rst_mid_read", o_MemLeer, 0);
    chk("rst_mid_stall", o_Stall, 0);
    chk("rst_mid_data", o_DatoLeido, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    last_dato = '0;
    run_load(32'h3004, 2'd0, 1'b0, 32'h1234_5678, 1, 1'b0, g);

    // Back-to-back byte loads: second accepted in the first's valid cycle.
    run_load(32'h101, 2'd1, 1'b1, 32'h0000_9A00, 0, 1'b0, g);
    run_load(32'h102, 2'd1, 1'b0, 32'h00C3_0000, 0, 1'b1, g);

    // Randomized loads, including back-to-back chains, misalignment and timeouts.
    prev_good = g;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rm = $urandom;
      rt = 2'($urandom % 4);
      if (($urandom % 3) != 0) ra[1:0] = (rt == 2'd0) ? 2'b00 : ((rt == 2'd2) ? {ra[1], 1'b0} : ra[1:0]);
      rw = ($urandom % 8 == 0) ? MAXW + 1 : int'($urandom % MAXW);
      run_load(ra, rt, 1'($urandom % 2), rm, rw, prev_good && ($urandom % 3 == 0), g);
      prev_good = g;
    end

    @(posedge i_clk); #1;
    i_Load = 1'b0;
    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
